huffman_stream_unpacker: RTL and testbench
==========================================

Name: huffman_stream_unpacker

Overview:
- Decoder-side reader for the packed compressed stream produced by the encoder's fixed-length packer.
- Accepts fixed-width, MSB-first packed words framed with sop/eop, holds them in a bit buffer, and presents a CODE_W-bit peek window to a downstream Huffman decoder.
- The downstream decoder consumes a variable number of bits per cycle.
- Tail-padding ones in the final word are handled, and the block resynchronises on the next sop.

Parameters:
WORD_W, 32, width of packed input word
CODE_W, 16, peek window width (max Huffman code + appended bits)
BUF_W, 2*WORD_W, bit buffer capacity (derived; must be >= WORD_W+CODE_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_data  in  WORD_W  packed word; first stream bit at bit WORD_W-1
in_valid  in  1  in_data valid
in_sop  in  1  word is first of frame
in_eop  in  1  word is last of frame (tail padded with ones)
in_ready  out  1  word accepted when in_valid & in_ready
win_data  out  CODE_W  next CODE_W stream bits, MSB = oldest bit; positions beyond bit_count read as 1
win_valid  out  1  window usable
bit_count  out  $clog2(BUF_W+1)  valid bits held
consume_en  in  1  consume request
consume_len  in  $clog2(CODE_W+1)  bits to drop (0..CODE_W)
frame_active  out  1  state != IDLE
frame_first  out  1  no bits yet consumed in current frame
flush  in  1  discard remainder of frame, return to IDLE
err  out  1  sticky over-consume flag

Behaviour:
- Reset (async, rst=1): state IDLE, buffer cleared, bit_count=0, win_valid=0, frame_active=0, frame_first=0, err=0, in_ready=1. All outputs derive from registers or from registered state plus combinational decode; there is no input-to-output combinational path except in_ready, which depends only on registers.
- States:
  - IDLE: in_ready=1. Words without in_sop are accepted and dropped.
  - IDLE -> RUN: on an accepted word with in_sop. The word is loaded and frame_first=1.
  - IDLE -> TAIL: on an accepted word with in_sop & in_eop. The word is loaded and frame_first=1.
  - RUN: in_ready = (bit_count <= BUF_W-WORD_W), using the registered count.
  - RUN -> TAIL: an accepted word with in_eop. An in_sop seen in RUN is ignored; the word is loaded as data.
  - TAIL: in_ready=0.
  - Any state -> IDLE: flush=1 clears the buffer, sets bit_count=0, and enters IDLE next cycle. flush has priority over load and consume in the same cycle.
  - TAIL auto-return: when bit_count reaches 0 the block also returns to IDLE.
- Window:
  - win_data = buffer[top CODE_W bits], with positions index >= bit_count forced to 1.
  - win_valid = (bit_count >= CODE_W) | (state==TAIL & bit_count>0).
- Latency: a word accepted in cycle N is visible in bit_count and window in cycle N+1. A consume in cycle N takes effect in cycle N+1.
- Consume:
  - Honoured only when consume_en & win_valid.
  - Legal consume: consume_len <= bit_count. The buffer shifts left by consume_len and bit_count -= consume_len.
  - Any honoured consume with consume_len > 0 clears frame_first.
  - If consume_len > bit_count: err is set (sticky until rst), the buffer is cleared, and bit_count=0.
- Simultaneous load and consume:
  - new_count = bit_count - consume_len + WORD_W.
  - The new word is inserted at bit position (bit_count - consume_len) from the top, i.e. after the shift.
  - bit_count never exceeds BUF_W; the in_ready rule guarantees this.
- consume_len=0 with consume_en: no change.
- A frame ending while bits remain requires flush to discard the padding ones.

Test Plan:
- Reset: assert rst mid-RUN with bit_count=40 -> same cycle: bit_count=0, win_valid=0, frame_active=0, in_ready=1; err cleared.
- Single-word frame: word 0xA5F01234 with sop+eop -> next cycle: TAIL, bit_count=32, win_data=0xA5F0, frame_first=1. Consume 4 -> win_data=0x5F01, bit_count=28, frame_first=0.
- Cross-word:
  - Input: word 0xFFFF0000 (sop) then 0x12345678; consume 8 in the cycle the second word loads.
  - Required: bit_count=56, win_data=0xFF00.
  - Then consume 16 -> win_data=0x0012, bit_count=40.
- Backpressure: load 0x11111111 (sop) then 0x22222222 with no consume -> bit_count=64, in_ready=0. Consume 16 -> next cycle bit_count=48, in_ready still 0. Consume 16 more -> bit_count=32, in_ready=1.
- Tail:
  - Input: last word 0x0000000A with sop+eop; consume 16, then 12.
  - Required after the 12-bit consume: win_data=0xAFFF, win_valid=1, bit_count=4.
  - Consume 4 -> bit_count=0, state IDLE next cycle.
  - Alternative path: flush at bit_count=4 -> IDLE, bit_count=0.
- Errors/garbage:
  - 0xDEADBEEF without sop in IDLE -> dropped, bit_count stays 0.
  - Then sop frame, bit_count=32; consume_len=16 twice, then a third consume_len=16 with bit_count=0 and state TAIL -> win_valid=0, ignored.
  - Forced: bit_count=8 in TAIL, consume 12 -> err=1, bit_count=0.

Source files
------------

// File: rtl/huffman_stream_unpacker.sv
// Bit-buffer front end for a Huffman decoder: unpacks MSB-first framed words and
// exposes a CODE_W-bit peek window that the decoder drains by a variable amount each cycle.
module huffman_stream_unpacker #(
  parameter  int WORD_W = 32,
  parameter  int CODE_W = 16,
  parameter  int BUF_W  = 2*WORD_W,
  localparam int CNT_W  = $clog2(BUF_W+1),
  localparam int LEN_W  = $clog2(CODE_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [CODE_W-1:0] win_data,
  output logic              win_valid,
  output logic [CNT_W-1:0]  bit_count,
  input  logic              consume_en,
  input  logic [LEN_W-1:0]  consume_len,
  output logic              frame_active,
  output logic              frame_first,
  input  logic              flush,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               err_q, err_d;

  logic               load;
  logic               honour;
  logic               over;
  logic [CNT_W-1:0]   len_ext;
  logic [BUF_W-1:0]   shifted;
  logic [CNT_W-1:0]   cnt_after;
  logic [BUF_W-1:0]   word_ext;

  assign len_ext  = {{(CNT_W-LEN_W){1'b0}}, consume_len};
  assign word_ext = {in_data, {(BUF_W-WORD_W){1'b0}}};
  assign load     = in_valid & in_ready & ((state_q == IDLE & in_sop) | state_q == RUN);
  assign honour   = consume_en & win_valid & (consume_len != '0);
  assign over     = honour & (len_ext > cnt_q);

  // NOTE: the bit buffer is an ordinary register, not a RAM, so it is reset like any other state.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Buffer bits below cnt_q are always zero, so a new word can simply be OR-ed in after the shift.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    shifted   = buf_q;
    cnt_after = cnt_q;
    first_d   = first_q;
    err_d     = err_q;
    if (honour) begin
      first_d = 1'b0;
      if (over) begin
        err_d     = 1'b1;
        shifted   = '0;
        cnt_after = '0;
      end else begin
        shifted   = buf_q << len_ext;
        cnt_after = cnt_q - len_ext;
      end
    end
    buf_d = shifted;
    cnt_d = cnt_after;
    if (load) begin
      buf_d = shifted | (word_ext >> cnt_after);
      cnt_d = cnt_after + CNT_W'(WORD_W);
      if (state_q == IDLE) first_d = 1'b1;
    end
    if (flush) begin
      buf_d   = '0;
      cnt_d   = '0;
      first_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load) state_d = in_eop ? TAIL : RUN;
      RUN:  if (load && in_eop) state_d = TAIL;
      TAIL: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = (cnt_q <= CNT_W'(BUF_W-WORD_W));
      default: in_ready = 1'b0;
    endcase
    frame_active = (state_q != IDLE);
    frame_first  = first_q;
    err          = err_q;
    bit_count    = cnt_q;
    win_valid    = (cnt_q >= CNT_W'(CODE_W)) | (state_q == TAIL && cnt_q != '0);
    // Positions past the valid count read as padding ones.
    for (int i = 0; i < CODE_W; i++) begin
      win_data[CODE_W-1-i] = (CNT_W'(i) < cnt_q) ? buf_q[BUF_W-1-i] : 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_stream_unpacker.sv
// Directed bench for huffman_stream_unpacker: each step queues its expected outputs
// and the queue is drained against the DUT after the clock edge.
module tb_huffman_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [15:0] win_data;
  logic        win_valid;
  logic [6:0]  bit_count;
  logic        consume_en;
  logic [4:0]  consume_len;
  logic        frame_active, frame_first, flush, err;

  int compared   = 0;
  int mismatched = 0;

  typedef enum {F_CNT, F_WIN, F_WVLD, F_RDY, F_ACT, F_FIRST, F_ERR} fld_e;
  typedef struct {
    string       tag;
    fld_e        fld;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  huffman_stream_unpacker dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .win_data(win_data), .win_valid(win_valid), .bit_count(bit_count),
    .consume_en(consume_en), .consume_len(consume_len),
    .frame_active(frame_active), .frame_first(frame_first),
    .flush(flush), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(fld_e f);
    case (f)
      F_CNT:   return {25'b0, bit_count};
      F_WIN:   return {16'b0, win_data};
      F_WVLD:  return {31'b0, win_valid};
      F_RDY:   return {31'b0, in_ready};
      F_ACT:   return {31'b0, frame_active};
      F_FIRST: return {31'b0, frame_first};
      default: return {31'b0, err};
    endcase
  endfunction

  task automatic expect_val(input string tag, input fld_e f, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.fld);
      compared++;
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] d, input logic v, input logic s, input logic e);
    in_data = d; in_valid = v; in_sop = s; in_eop = e;
  endtask

  task automatic set_cons(input logic en, input logic [4:0] len);
    consume_en = en; consume_len = len;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    expect_val("flush_cnt", F_CNT, 0);
    expect_val("flush_act", F_ACT, 0);
    check_all();
  endtask

  // Two-word load with an 8-bit consume on the second word, then a 16-bit consume.
  task automatic cross_word();
    set_in(32'hFFFF0000, 1, 1, 0);
    cycle();
    set_in(32'h12345678, 1, 0, 0);
    set_cons(1, 8);
    cycle();
    set_in(0, 0, 0, 0);
    set_cons(0, 0);
    expect_val("cross_cnt56", F_CNT, 56);
    expect_val("cross_win_ff00", F_WIN, 32'hFF00);
    expect_val("cross_act", F_ACT, 1);
    check_all();
    set_cons(1, 16);
    cycle();
    set_cons(0, 0);
    expect_val("cross_win_0012", F_WIN, 32'h0012);
    expect_val("cross_cnt40", F_CNT, 40);
    check_all();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    set_cons(0, 0);
    flush = 1'b0;
    #12;
    expect_val("rst_cnt", F_CNT, 0);
    expect_val("rst_wvld", F_WVLD, 0);
    expect_val("rst_act", F_ACT, 0);
    expect_val("rst_first", F_FIRST, 0);
    expect_val("rst_err", F_ERR, 0);
    expect_val("rst_rdy", F_RDY, 1);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Word without sop in IDLE is dropped.
    set_in(32'hDEADBEEF, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0);
    expect_val("garbage_cnt", F_CNT, 0);
    expect_val("garbage_act", F_ACT, 0);
    check_all();

    // Single-word frame.
    set_in(32'hA5F01234, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0);
    expect_val("single_cnt", F_CNT, 32);
    expect_val("single_win", F_WIN, 32'hA5F0);
    expect_val("single_wvld", F_WVLD, 1);
    expect_val("single_first", F_FIRST, 1);
    expect_val("single_tail_rdy", F_RDY, 0);
    expect_val("single_act", F_ACT, 1);
    check_all();
    set_cons(1, 4);
    cycle();
    set_cons(0, 0);
    expect_val("single_win_c4", F_WIN, 32'h5F01);
    expect_val("single_cnt_c4", F_CNT, 28);
    expect_val("single_first_c4", F_FIRST, 0);
    check_all();
    do_flush();

    cross_word();
    do_flush();

    // Backpressure.
    set_in(32'h11111111, 1, 1, 0);
    cycle();
    set_in(32'h22222222, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0);
    expect_val("bp_cnt64", F_CNT, 64);
    expect_val("bp_rdy64", F_RDY, 0);
    check_all();
    set_cons(1, 16);
    cycle();
    expect_val("bp_cnt48", F_CNT, 48);
    expect_val("bp_rdy48", F_RDY, 0);
    check_all();
    cycle();
    set_cons(0, 0);
    expect_val("bp_cnt32", F_CNT, 32);
    expect_val("bp_rdy32", F_RDY, 1);
    check_all();
    do_flush();

    // Tail padding and auto-return.
    set_in(32'h0000000A, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0);
    set_cons(1, 16);
    cycle();
    set_cons(1, 12);
    cycle();
    set_cons(0, 0);
    expect_val("tail_win", F_WIN, 32'hAFFF);
    expect_val("tail_wvld", F_WVLD, 1);
    expect_val("tail_cnt4", F_CNT, 4);
    check_all();
    set_cons(1, 4);
    cycle();
    set_cons(0, 0);
    expect_val("tail_cnt0", F_CNT, 0);
    expect_val("tail_wvld0", F_WVLD, 0);
    check_all();
    cycle();
    expect_val("tail_idle_act", F_ACT, 0);
    expect_val("tail_idle_rdy", F_RDY, 1);
    check_all();

    // Same tail, discarded by flush at four bits.
    set_in(32'h0000000A, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0);
    set_cons(1, 16);
    cycle();
    set_cons(1, 12);
    cycle();
    set_cons(0, 0);
    expect_val("tailf_cnt4", F_CNT, 4);
    check_all();
    do_flush();

    // Consume attempted on an empty TAIL is ignored.
    set_in(32'h0F0F0F0F, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0);
    set_cons(1, 16);
    cycle();
    cycle();
    expect_val("empty_cnt0", F_CNT, 0);
    expect_val("empty_wvld", F_WVLD, 0);
    expect_val("empty_act_tail", F_ACT, 1);
    check_all();
    cycle();
    set_cons(0, 0);
    expect_val("empty_err", F_ERR, 0);
    expect_val("empty_idle", F_ACT, 0);
    check_all();

    // Over-consume in TAIL sets sticky err.
    set_in(32'h12345678, 1, 1, 1);
    cycle();
    set_in(0, 0, 0, 0);
    set_cons(1, 16);
    cycle();
    set_cons(1, 8);
    cycle();
    set_cons(0, 0);
    expect_val("over_cnt8", F_CNT, 8);
    expect_val("over_win", F_WIN, 32'h78FF);
    expect_val("over_wvld8", F_WVLD, 1);
    check_all();
    set_cons(1, 12);
    cycle();
    set_cons(0, 0);
    expect_val("over_err", F_ERR, 1);
    expect_val("over_cnt0", F_CNT, 0);
    check_all();
    cycle();
    expect_val("over_err_sticky", F_ERR, 1);
    expect_val("over_idle", F_ACT, 0);
    check_all();

    // Asynchronous reset mid-RUN with 40 bits held.
    cross_word();
    #2;
    rst = 1'b1;
    #1;
    expect_val("arst_cnt", F_CNT, 0);
    expect_val("arst_wvld", F_WVLD, 0);
    expect_val("arst_act", F_ACT, 0);
    expect_val("arst_rdy", F_RDY, 1);
    expect_val("arst_err", F_ERR, 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
